dsc_bs2bin: RTL and testbench

- Deterministic stochastic computing (DSC) bitstream-to-binary converter.
- Sits at the receiving end of a DSC datapath. Consumes a unipolar bitstream, one bit per accepted beat, over a window of 2^WIDTH beats.
- Returns the ones-count as a binary word through a valid/ready output handshake.
- Supports early termination (stop), for datapaths that finish before the full window, and applies backpressure on the bitstream while an unconsumed result is pending.

---
 rtl/dsc_bs2bin.sv | 179 +++++++++++++++++
 tb/tb_dsc_bs2bin.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dsc_bs2bin.sv
// dsc_bs2bin: deterministic stochastic computing bitstream-to-binary converter.
// Counts the ones in a unipolar bitstream over a 2^WIDTH-beat window, or
// over a shorter window ended by stop. The count is returned on a
// valid/ready output. A second result that completes while the first is
// still unconsumed is parked in a pending register. The bitstream is
// stalled until that pending result is moved to the output.
// Optional feature macro: DSC_BS2BIN_AUTORESTART_EN. When defined, a
// full-window completion re-arms accumulation without a start pulse.
module dsc_bs2bin #(
    parameter int WIDTH     = 10,
    parameter int OUT_WIDTH = WIDTH + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 bs_in,
    input  logic                 bs_valid,
    output logic                 bs_ready,
    output logic [OUT_WIDTH-1:0] bin_out,
    output logic [WIDTH:0]       beats_out,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    // Value of beat_cnt on the beat that closes a full window.
    localparam logic [WIDTH:0] LAST_BEAT = {1'b0, {WIDTH{1'b1}}};

    logic [1:0]           state_q,      state_d;
    logic [OUT_WIDTH-1:0] ones_q,       ones_d;
    logic [WIDTH:0]       beat_q,       beat_d;
    logic [OUT_WIDTH-1:0] bin_q,        bin_d;
    logic [WIDTH:0]       beats_q,      beats_d;
    logic                 valid_q,      valid_d;
    logic [OUT_WIDTH-1:0] pend_bin_q,   pend_bin_d;
    logic [WIDTH:0]       pend_beats_q, pend_beats_d;

    logic                 beat;
    logic                 last_beat;
    logic                 win_done;
    logic                 out_free;
    logic [OUT_WIDTH-1:0] fin_cnt;
    logic [WIDTH:0]       fin_beats;
    logic                 done_restart;
    logic                 hold_restart;

    assign bs_ready  = (state_q == S_ACCUM);
    assign busy      = (state_q != S_IDLE);
    assign bin_out   = bin_q;
    assign beats_out = beats_q;
    assign out_valid = valid_q;

    assign beat      = bs_valid & bs_ready;
    assign last_beat = beat && (beat_q == LAST_BEAT);
    assign win_done  = (state_q == S_ACCUM) && (last_beat || stop);
    // The output register can take a new result this cycle.
    assign out_free  = !valid_q || out_ready;
    // Final values include any beat accepted in the completing cycle.
    assign fin_cnt   = ones_q + OUT_WIDTH'(beat & bs_in);
    assign fin_beats = beat_q + (WIDTH+1)'(beat);

`ifdef DSC_BS2BIN_AUTORESTART_EN
    // Remembers whether the parked result came from a full window.
    logic pend_restart_q, pend_restart_d;

    assign done_restart = last_beat;
    assign hold_restart = pend_restart_q;

    // Restart flag for the parked result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) pend_restart_q <= 1'b0;
        else      pend_restart_q <= pend_restart_d;
    end
`else
    assign done_restart = 1'b0;
    assign hold_restart = 1'b0;
`endif

    // Next-state and datapath decisions for the window FSM and output.
    always_comb begin
        // NOTE: every variable gets a default first, so no path infers a latch.
        state_d      = state_q;
        ones_d       = ones_q;
        beat_d       = beat_q;
        bin_d        = bin_q;
        beats_d      = beats_q;
        valid_d      = valid_q;
        pend_bin_d   = pend_bin_q;
        pend_beats_d = pend_beats_q;
`ifdef DSC_BS2BIN_AUTORESTART_EN
        pend_restart_d = pend_restart_q;
`endif

        // A consumed result drops valid unless a new one loads below.
        if (valid_q && out_ready) valid_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACCUM;
                    ones_d  = '0;
                    beat_d  = '0;
                end
            end
            S_ACCUM: begin
                if (beat) begin
                    ones_d = fin_cnt;
                    beat_d = fin_beats;
                end
                if (win_done) begin
                    if (out_free) begin
                        bin_d   = fin_cnt;
                        beats_d = fin_beats;
                        valid_d = 1'b1;
                        if (done_restart) begin
                            ones_d = '0;
                            beat_d = '0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        pend_bin_d   = fin_cnt;
                        pend_beats_d = fin_beats;
                        state_d      = S_HOLD;
`ifdef DSC_BS2BIN_AUTORESTART_EN
                        pend_restart_d = last_beat;
`endif
                    end
                end
            end
            S_HOLD: begin
                if (valid_q && out_ready) begin
                    bin_d   = pend_bin_q;
                    beats_d = pend_beats_q;
                    valid_d = 1'b1;
                    if (hold_restart) begin
                        state_d = S_ACCUM;
                        ones_d  = '0;
                        beat_d  = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            ones_q       <= '0;
            beat_q       <= '0;
            bin_q        <= '0;
            beats_q      <= '0;
            valid_q      <= 1'b0;
            // NOTE: the pending register is reset so a reset discards any parked result.
            pend_bin_q   <= '0;
            pend_beats_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep all registers updating from the same pre-edge values.
            state_q      <= state_d;
            ones_q       <= ones_d;
            beat_q       <= beat_d;
            bin_q        <= bin_d;
            beats_q      <= beats_d;
            valid_q      <= valid_d;
            pend_bin_q   <= pend_bin_d;
            pend_beats_q <= pend_beats_d;
        end
    end

endmodule

// File: tb/tb_dsc_bs2bin.sv
// tb_dsc_bs2bin: directed self-checking bench for dsc_bs2bin with WIDTH=4.
// Expectations follow DSC_BS2BIN_AUTORESTART_EN when it is defined.
module tb_dsc_bs2bin;

    localparam int W  = 4;
    localparam int OW = W + 1;
`ifdef DSC_BS2BIN_AUTORESTART_EN
    localparam logic AUTO = 1'b1;
`else
    localparam logic AUTO = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          bs_in = 1'b0;
    logic          bs_valid = 1'b0;
    logic          bs_ready;
    logic [OW-1:0] bin_out;
    logic [W:0]    beats_out;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          busy;

    int n_cmp = 0;
    int n_bad = 0;

    dsc_bs2bin #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .bs_in     (bs_in),
        .bs_valid  (bs_valid),
        .bs_ready  (bs_ready),
        .bin_out   (bin_out),
        .beats_out (beats_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; samples and drives happen 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0; stop = 1'b0; bs_valid = 1'b0; bs_in = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic start_win();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Continuous beats pat[lo..hi].
    task automatic feed(input logic [15:0] pat, input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            bs_valid = 1'b1;
            bs_in    = pat[i];
            tick();
        end
        bs_valid = 1'b0;
        bs_in    = 1'b0;
    endtask

    task automatic full_window(input string tag, input logic [15:0] pat, input int exp_cnt);
        do_reset();
        out_ready = 1'b1;
        start_win();
        feed(pat, 0, 14);
        check({tag, "_valid_before_last"}, out_valid, 0);
        feed(pat, 15, 15);
        check({tag, "_valid_after_last"}, out_valid, 1);
        check({tag, "_bin"}, bin_out, exp_cnt);
        check({tag, "_beats"}, beats_out, 16);
        check({tag, "_busy"}, busy, AUTO);
        tick();
        check({tag, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        logic [15:0] pat;
        logic [OW-1:0] res [0:3];
        int nres;
        int gaps;
        int vcnt;

        // Reset state
        tick();
        check("rst_bin", bin_out, 0);
        check("rst_beats", beats_out, 0);
        check("rst_valid", out_valid, 0);
        check("rst_ready", bs_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        tick();

        // Stop in IDLE is ignored
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("idle_stop_valid", out_valid, 0);
        check("idle_stop_busy", busy, 0);

        // Reset during ACCUM after 5 beats
        start_win();
        check("accum_ready", bs_ready, 1);
        pat = 16'h001F;
        feed(pat, 0, 4);
        #2 rst = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ready", bs_ready, 0);
        check("midrst_valid", out_valid, 0);
        check("midrst_bin", bin_out, 0);
        #3 rst = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) vcnt++;
        end
        check("midrst_no_result", vcnt, 0);
        check("midrst_idle", busy, 0);

        // Full windows
        full_window("w11", 16'hFFE0, 11);
        full_window("w16", 16'hFFFF, 16);
        full_window("w0",  16'h0000, 0);

        // Gapped input, then stop with a concurrent one-beat
        do_reset();
        start_win();
        pat = 16'b0000_0000_0010_1011;  // beats: 1,1,0,1,0,1
        for (int i = 0; i < 6; i++) begin
            bs_valid = 1'b1; bs_in = pat[i];
            tick();
            bs_valid = 1'b0; bs_in = 1'b0;
            tick();
        end
        check("gap_no_valid", out_valid, 0);
        stop = 1'b1; bs_valid = 1'b1; bs_in = 1'b1;
        tick();
        stop = 1'b0; bs_valid = 1'b0; bs_in = 1'b0;
        check("stop_valid", out_valid, 1);
        check("stop_bin", bin_out, 5);
        check("stop_beats", beats_out, 7);
        check("stop_idle", busy, 0);

        // Zero-beat stop
        do_reset();
        start_win();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("zstop_valid", out_valid, 1);
        check("zstop_bin", bin_out, 0);
        check("zstop_beats", beats_out, 0);

        // Backpressure: second completion parks in HOLD
        do_reset();
        out_ready = 1'b0;
        start_win();
        pat = 16'h000F;
        feed(pat, 0, 15);
        check("bp1_valid", out_valid, 1);
        check("bp1_bin", bin_out, 4);
        start_win();
        pat = 16'h00FF;
        feed(pat, 0, 15);
        check("bp_hold_busy", busy, 1);
        check("bp_hold_ready", bs_ready, 0);
        check("bp_hold_bin", bin_out, 4);
        tick();
        tick();
        check("bp_hold_bin_stable", bin_out, 4);
        check("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        check("bp2_valid", out_valid, 1);
        check("bp2_bin", bin_out, 8);
        check("bp2_beats", beats_out, 16);
        check("bp2_busy", busy, AUTO);
        tick();
        check("bp2_drop", out_valid, 0);

        // 48 continuous beats after a single start
        do_reset();
        out_ready = 1'b1;
        start_win();
        nres = 0;
        gaps = 0;
        for (int i = 0; i < 48; i++) begin
            bs_valid = 1'b1;
            bs_in    = (i % 3 == 0);
            if (!bs_ready) gaps++;
            tick();
            if (out_valid) begin
                if (nres < 4) res[nres] = bin_out;
                nres++;
            end
        end
        bs_valid = 1'b0; bs_in = 1'b0;
        check("run48_results", nres, AUTO ? 3 : 1);
        check("run48_gaps", gaps, AUTO ? 0 : 32);
        check("run48_res0", res[0], 6);
        if (AUTO) begin
            check("run48_res1", res[1], 5);
            check("run48_res2", res[2], 5);
        end
        check("run48_ready_after", bs_ready, AUTO);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
